// File: rtl/bitrev_word_serializer_if.sv
// Word-in / beat-out valid-ready bundle for the bit-reverse serializer.
// The serializer side uses the slave modport; the producer/consumer side uses master.
interface bitrev_word_serializer_if #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/bitrev_word_serializer.sv
// Accepts a word, reverses its slice order ({<< SLICE_W {word}}), and emits it
// as BEATS narrow beats, least-significant beat first, with no bubble between words.
module bitrev_word_serializer #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 1,
  parameter int OUT_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  bitrev_word_serializer_if.slave  bus,
  output logic                     busy,
  output logic [CNT_W-1:0]         word_count
);

  localparam int BEATS  = DATA_W / OUT_W;
  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                       state_p0, state_n;
  logic [BEAT_W-1:0]            beat_p0, beat_n;
  logic [BEATS-1:0][OUT_W-1:0]  held_p0;
  logic [CNT_W-1:0]             count_p0;
  logic                         load;
  logic                         word_done;
  logic                         last_beat;

  // Slice j of the input lands in slice NSLICE-1-j; bits inside a slice keep order.
  function automatic logic [DATA_W-1:0] slice_rev(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int j = 0; j < NSLICE; j++) begin
      r[(NSLICE-1-j)*SLICE_W +: SLICE_W] = w[j*SLICE_W +: SLICE_W];
    end
    return r;
  endfunction

  assign last_beat = (beat_p0 == LAST_BEAT);

  always_comb begin
    state_n       = state_p0;
    beat_n        = beat_p0;
    load          = 1'b0;
    word_done     = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    unique case (state_p0)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          load    = 1'b1;
          beat_n  = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        bus.out_valid = 1'b1;
        bus.out_last  = last_beat;
        bus.in_ready  = last_beat & bus.out_ready;
        if (bus.out_ready) begin
          if (!last_beat) begin
            beat_n = beat_p0 + 1'b1;
          end else begin
            word_done = 1'b1;
            beat_n    = '0;
            // A waiting word is taken on the final beat so the stream never idles.
            if (bus.in_valid) begin
              load = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Stage p0: held word, beat index and word counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= IDLE;
      beat_p0  <= '0;
      held_p0  <= '0;
      count_p0 <= '0;
    end else begin
      state_p0 <= state_n;
      beat_p0  <= beat_n;
      if (load) begin
        held_p0 <= slice_rev(bus.in_data);
      end
      if (word_done) begin
        count_p0 <= count_p0 + 1'b1;
      end
    end
  end

  assign bus.out_data = held_p0[beat_p0];
  assign busy         = (state_p0 == SHIFT);
  assign word_count   = count_p0;

endmodule
